// File: rtl/ntt_core_unloader.sv
// ntt_core_unloader: walks the coefficient memory of one ntt_core word by
// word, captures r1..r4 for each address once the read data has settled,
// and replays them as a serial valid/ready coefficient stream.
module ntt_core_unloader #(
  parameter int ADDR_WIDTH   = 9,
  parameter int WORD_COUNT   = 512,
  parameter int DATA_WIDTH   = 30,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  read_mode,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] r1,
  input  logic [DATA_WIDTH-1:0] r2,
  input  logic [DATA_WIDTH-1:0] r3,
  input  logic [DATA_WIDTH-1:0] r4,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [ADDR_WIDTH+1:0] out_index
);

  // The wait counter only has to reach READ_LATENCY-1.
  localparam int WAIT_WIDTH = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int INDEX_WIDTH = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORD_COUNT - 1);
  localparam logic [WAIT_WIDTH-1:0] LAST_WAIT = WAIT_WIDTH'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                          state_r, state_s;
  logic [ADDR_WIDTH-1:0]           word_r, word_s;
  logic [WAIT_WIDTH-1:0]           wait_r, wait_s;
  logic [1:0]                      beat_r, beat_s;
  logic [3:0][DATA_WIDTH-1:0]      hold_r, hold_s;
  logic [INDEX_WIDTH-1:0]          index_r, index_s;

  logic                            busy_r, busy_s;
  logic                            done_r, done_s;
  logic                            valid_r, valid_s;
  logic                            last_r, last_s;
  logic [DATA_WIDTH-1:0]           data_r, data_s;

  // Next-state, counter and capture logic of the unload sequencer.
  always_comb begin
    state_s = state_r;
    word_s  = word_r;
    wait_s  = wait_r;
    beat_s  = beat_r;
    hold_s  = hold_r;
    index_s = index_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH;
          word_s  = '0;
          beat_s  = 2'd0;
          index_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_WAIT;
        wait_s  = '0;
      end
      ST_WAIT: begin
        if (wait_r == LAST_WAIT) begin
          // Read data is valid now: snapshot all four lanes, r1 first.
          state_s = ST_EMIT;
          hold_s  = {r4, r3, r2, r1};
          beat_s  = 2'd0;
        end else begin
          wait_s = wait_r + WAIT_WIDTH'(1);
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          beat_s  = beat_r + 2'd1;
          index_s = index_r + INDEX_WIDTH'(1);
          if (beat_r == 2'd3) begin
            if (word_r == LAST_WORD) begin
              // Run complete; leave counters at their idle value of zero.
              state_s = ST_DONE;
              word_s  = '0;
              index_s = '0;
            end else begin
              state_s = ST_FETCH;
              word_s  = word_r + ADDR_WIDTH'(1);
            end
          end else begin
            state_s = ST_EMIT;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        index_s = '0;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so the
  // ports themselves come straight from flops.
  always_comb begin
    busy_s  = (state_s == ST_FETCH) || (state_s == ST_WAIT) || (state_s == ST_EMIT);
    done_s  = (state_s == ST_DONE);
    valid_s = (state_s == ST_EMIT);
    last_s  = valid_s && (word_s == LAST_WORD) && (beat_s == 2'd3);
    if (valid_s) begin
      data_s = hold_s[beat_s];
    end else begin
      data_s = '0;
    end
  end

  // State, counters, hold register and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      word_r  <= '0;
      wait_r  <= '0;
      beat_r  <= 2'd0;
      hold_r  <= '0;
      index_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= '0;
    end else begin
      state_r <= state_s;
      word_r  <= word_s;
      wait_r  <= wait_s;
      beat_r  <= beat_s;
      hold_r  <= hold_s;
      index_r <= index_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      data_r  <= data_s;
    end
  end

  assign busy         = busy_r;
  assign read_mode    = busy_r;
  assign done         = done_r;
  assign read_address = word_r;
  assign out_valid    = valid_r;
  assign out_last     = last_r;
  assign out_data     = data_r;
  assign out_index    = index_r;

endmodule
